sweep_max_tracker: RTL and testbench

- Calibration sequencer sitting directly upstream of the servo PWM generator.
- It drives the generator's EN/DIR/ES/MC controls and one full 0-180 deg sweep.
- During the sweep it records the irradiance peak against the reported servo pulse width.
- It then commands the servo back to that peak and holds it there.
- One instance per axis (horizontal, vertical).

---
 rtl/sweep_max_tracker_pkg.sv | 29 ++
 rtl/sweep_max_tracker_peak_hold.sv | 57 +++++
 rtl/sweep_max_tracker.sv | 166 ++++++++++++++++
 tb/tb_sweep_max_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_max_tracker_pkg.sv
// Shared types and constants for the servo sweep/peak calibration sequencer.
// Pulse-width constants are shared with the downstream PWM generator.
package sweep_max_tracker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StSettle,
    StHold
  } state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;
  localparam logic [1:0] DIR_CW   = 2'b10;

  localparam int unsigned PW_W             = 15;
  localparam int unsigned PW_MIN_DEFAULT   = 5000;
  localparam int unsigned PW_LIMIT_DEFAULT = 25000;
  localparam int unsigned PW_PARK_DEFAULT  = 15000;

  function automatic logic [1:0] dir_for_state(input state_e s);
    case (s)
      StSweep:          return DIR_CCW;
      StSettle, StHold: return DIR_CW;
      default:          return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/sweep_max_tracker_peak_hold.sv
// Running-maximum latch: keeps the largest sample and the position it was seen at.
// Strict compare, so ties keep the earliest position; park overrides the position only.
module sweep_max_tracker_peak_hold #(
  parameter int unsigned SampleW  = 12,
  parameter int unsigned PosW     = 15,
  parameter int unsigned ClearPos = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [SampleW-1:0] sample_i,
  input  logic [PosW-1:0]    pos_i,
  input  logic               park_i,
  input  logic [PosW-1:0]    park_pos_i,
  output logic [SampleW-1:0] max_d_o,
  output logic [SampleW-1:0] max_o,
  output logic [PosW-1:0]    pos_o
);

  logic [SampleW-1:0] max_q, max_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic               upd;

  always_comb begin
    upd   = en_i && (sample_i > max_q);
    max_d = max_q;
    pos_d = pos_q;
    if (clear_i) begin
      max_d = '0;
      pos_d = PosW'(ClearPos);
    end else begin
      if (upd) begin
        max_d = sample_i;
        pos_d = pos_i;
      end
      if (park_i) begin
        pos_d = park_pos_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
      pos_q <= PosW'(ClearPos);
    end else begin
      max_q <= max_d;
      pos_q <= pos_d;
    end
  end

  assign max_d_o = max_d;
  assign max_o   = max_q;
  assign pos_o   = pos_q;

endmodule

// File: rtl/sweep_max_tracker.sv
// Calibration sequencer: one 0-180 deg sweep, track the irradiance peak, settle and hold there.
// Optional low-light fallback to a park position is enabled with `define DARK_REJECT_EN.
module sweep_max_tracker
  import sweep_max_tracker_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = 12,
  parameter int unsigned PW_MIN         = PW_MIN_DEFAULT,
  parameter int unsigned PW_LIMIT       = PW_LIMIT_DEFAULT,
  parameter int unsigned SETTLE_CYCLES  = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned DARK_THRESH    = 200,
  parameter int unsigned PW_PARK        = PW_PARK_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [PW_W-1:0]     pulse_width_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                en_o,
  output logic [1:0]          dir_o,
  output logic                es_o,
  output logic                mc_o,
  output logic [PW_W-1:0]     pulse_width_max_o,
  output logic [SAMPLE_W-1:0] max_sample_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic                dark_o
);

  // One counter serves both SWEEP timeout and SETTLE; it is cleared on every state change.
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              dark_q, dark_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic              es_q, es_d;
  logic              mc_q, mc_d;
  logic              busy_q, busy_d;
  logic [1:0]        dir_q, dir_d;

  logic              sweep_entry, sweep_exit, sweep_end, sample_en, park;
  logic [SAMPLE_W-1:0] peak_max_d;

  assign sweep_end = sample_valid_i && (pulse_width_i >= PW_W'(PW_LIMIT));
  assign sample_en = sample_valid_i && (state_q == StSweep);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    sweep_entry = 1'b0;
    sweep_exit  = 1'b0;
    case (state_q)
      StIdle, StHold: begin
        if (start_i) begin
          state_d     = StSweep;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          sweep_entry = 1'b1;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 1'b1;
        // A genuine end point beats a timeout landing on the same cycle.
        if (sweep_end) begin
          state_d    = StSettle;
          cnt_d      = '0;
          sweep_exit = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = StSettle;
          cnt_d      = '0;
          timeout_d  = 1'b1;
          sweep_exit = 1'b1;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DARK_REJECT_EN
  assign park = sweep_exit && (peak_max_d < SAMPLE_W'(DARK_THRESH));
`else
  assign park = 1'b0;
`endif

  assign dark_d = sweep_entry ? 1'b0 : (park ? 1'b1 : dark_q);

  // Output pins are registered copies of what the next state implies.
  always_comb begin
    en_d   = (state_d != StIdle);
    dir_d  = dir_for_state(state_d);
    es_d   = (state_d == StSweep);
    mc_d   = (state_d == StSettle) || (state_d == StHold);
    busy_d = (state_d == StSweep) || (state_d == StSettle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      dark_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      dir_q     <= DIR_STOP;
      es_q      <= 1'b0;
      mc_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      dark_q    <= dark_d;
      done_q    <= done_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      es_q      <= es_d;
      mc_q      <= mc_d;
      busy_q    <= busy_d;
    end
  end

  sweep_max_tracker_peak_hold #(
    .SampleW (SAMPLE_W),
    .PosW    (PW_W),
    .ClearPos(PW_MIN)
  ) u_peak_hold (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (sweep_entry),
    .en_i      (sample_en),
    .sample_i  (sample_i),
    .pos_i     (pulse_width_i),
    .park_i    (park),
    .park_pos_i(PW_W'(PW_PARK)),
    .max_d_o   (peak_max_d),
    .max_o     (max_sample_o),
    .pos_o     (pulse_width_max_o)
  );

  assign en_o      = en_q;
  assign dir_o     = dir_q;
  assign es_o      = es_q;
  assign mc_o      = mc_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign dark_o    = dark_q;

endmodule

// File: tb/tb_sweep_max_tracker.sv
// Directed self-checking bench for sweep_max_tracker with shortened sweep/settle timing.
module tb_sweep_max_tracker;

  localparam int unsigned SW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [14:0]   pulse_width;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic          en, es, mc, busy, done, timeout, dark;
  logic [1:0]    dir;
  logic [14:0]   pw_max;
  logic [SW-1:0] max_sample;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  sweep_max_tracker #(
    .SAMPLE_W      (SW),
    .PW_MIN        (5000),
    .PW_LIMIT      (5400),
    .SETTLE_CYCLES (20),
    .TIMEOUT_CYCLES(500),
    .DARK_THRESH   (200),
    .PW_PARK       (15000)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .pulse_width_i    (pulse_width),
    .sample_valid_i   (sample_valid),
    .sample_i         (sample),
    .en_o             (en),
    .dir_o            (dir),
    .es_o             (es),
    .mc_o             (mc),
    .pulse_width_max_o(pw_max),
    .max_sample_o     (max_sample),
    .busy_o           (busy),
    .done_o           (done),
    .timeout_o        (timeout),
    .dark_o           (dark)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_sample(input int pw, input int s);
    pulse_width  = 15'(pw);
    sample       = SW'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (done !== 1'b1 && cnt < 100);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pulse_width = '0; sample_valid = 1'b0; sample = '0;
    #12;
    check_eq("rst_en", en, 0);
    check_eq("rst_dir", dir, 0);
    check_eq("rst_es", es, 0);
    check_eq("rst_mc", mc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_dark", dark, 0);
    check_eq("rst_pwmax", pw_max, 5000);
    check_eq("rst_max", max_sample, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_en", en, 0);

    // Normal sweep with a tie at 900: earliest position must win.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("sweep_en", en, 1);
    check_eq("sweep_dir", dir, 1);
    check_eq("sweep_es", es, 1);
    check_eq("sweep_busy", busy, 1);
    check_eq("sweep_mc", mc, 0);
    give_sample(5000, 100);
    give_sample(5100, 900);
    check_eq("mid_max", max_sample, 900);
    check_eq("mid_pwmax", pw_max, 5100);
    give_sample(5200, 900);
    give_sample(5300, 400);
    give_sample(5400, 50);
    check_eq("settle_dir", dir, 2);
    check_eq("settle_mc", mc, 1);
    check_eq("settle_es", es, 0);
    check_eq("settle_busy", busy, 1);
    check_eq("peak_pwmax", pw_max, 5100);
    check_eq("peak_max", max_sample, 900);

    // START and a stray sample during SETTLE must both be ignored.
    n = 0;
    do begin
      start        = (n == 5);
      sample_valid = (n == 8);
      sample       = SW'(4000);
      pulse_width  = 15'd5000;
      tick();
      n++;
    end while (done !== 1'b1 && n < 100);
    start = 1'b0; sample_valid = 1'b0;
    check_eq("done_latency", n, 20);
    check_eq("hold_max", max_sample, 900);
    check_eq("hold_pwmax", pw_max, 5100);
    check_eq("hold_busy", busy, 0);
    check_eq("hold_dir", dir, 2);
    tick();
    check_eq("done_pulse", done, 0);
    check_eq("hold_mc", mc, 1);

    // Restart from HOLD, then time out with the width frozen below the limit.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_max", max_sample, 0);
    check_eq("restart_pwmax", pw_max, 5000);
    check_eq("restart_dir", dir, 1);
    pulse_width = 15'd5200;
    n = 0;
    do begin
      start        = (n == 10);
      sample_valid = (n == 3);
      sample       = SW'(300);
      tick();
      n++;
    end while (mc !== 1'b1 && n < 700);
    start = 1'b0; sample_valid = 1'b0;
    check_eq("timeout_latency", n, 500);
    check_eq("timeout_flag", timeout, 1);
    check_eq("timeout_max", max_sample, 300);
    check_eq("timeout_pwmax", pw_max, 5200);
    check_eq("timeout_busy", busy, 1);
    wait_done(n);
    check_eq("timeout_done_latency", n, 20);
    check_eq("timeout_sticky", timeout, 1);

    // New sweep clears TIMEOUT; end point and timeout coincide, end must win.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("timeout_clear", timeout, 0);
    n = 0;
    do begin
      sample_valid = (n == 499);
      pulse_width  = (n == 499) ? 15'd5400 : 15'd5200;
      sample       = SW'(70);
      tick();
      n++;
    end while (mc !== 1'b1 && n < 700);
    sample_valid = 1'b0;
    check_eq("tie_latency", n, 500);
    check_eq("tie_timeout", timeout, 0);
    check_eq("tie_max", max_sample, 70);
`ifdef DARK_REJECT_EN
    check_eq("tie_pwmax", pw_max, 15000);
    check_eq("tie_dark", dark, 1);
`else
    check_eq("tie_pwmax", pw_max, 5400);
    check_eq("tie_dark", dark, 0);
`endif
    wait_done(n);
    check_eq("tie_done_latency", n, 20);

    // Asynchronous reset mid-sweep.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_en", en, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_dir", dir, 0);
    check_eq("midrst_es", es, 0);
    check_eq("midrst_pwmax", pw_max, 5000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("midrst_idle", en, 0);

    // Dim sweep: every sample below the dark threshold.
    start = 1'b1; tick(); start = 1'b0;
    give_sample(5100, 100);
    give_sample(5400, 150);
    check_eq("dim_max", max_sample, 150);
`ifdef DARK_REJECT_EN
    check_eq("dim_pwmax", pw_max, 15000);
    check_eq("dim_dark", dark, 1);
`else
    check_eq("dim_pwmax", pw_max, 5400);
    check_eq("dim_dark", dark, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
